// File: rtl/dpram_sdp_clr_pkg.sv
// dpram_pkg: shared state encoding, read-latency legality check and default widths
package dpram_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic logic rd_lat_ok(input int lat);
    return lat == 1 || lat == 2;
  endfunction
endpackage

// File: rtl/dpram_sdp_clr_if.sv
// dpram_sdp_clr_if: clear, write and read port bundle of the simple dual-port RAM
interface dpram_sdp_clr_if import dpram_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              clr;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_drop;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, wr_drop, rd_data, rd_valid
  );
  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output busy, wr_drop, rd_data, rd_valid
  );
endinterface

// File: rtl/dpram_sdp_clr_mem_core.sv
// sdp_mem_core: inferable RAM array with one write port, one registered read port and collision forwarding
module sdp_mem_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  assign o_rdata = r_rdata;
  // array write; the array itself carries no reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // read register: holds between reads, forwards same-address write data when BYPASS is set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= (BYPASS != 0 && i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
endmodule

// File: rtl/dpram_sdp_clr.sv
// dpram_sdp_clr: parametrised simple dual-port RAM with clear engine, selectable read latency and rd_valid
module dpram_sdp_clr import dpram_pkg::*; #(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              RD_LAT   = 1,
  parameter int              BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  dpram_sdp_clr_if.slave bus
);
  localparam logic LAT2 = rd_lat_ok(RD_LAT) && RD_LAT == 2;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wr_drop, r_vld1;
  logic              w_busy, w_we, w_re, w_last;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata, w_core_rd;
  assign w_busy      = r_state == ST_CLEAR;
  assign w_last      = r_cnt == {ADDR_W{1'b1}};
  assign w_we        = w_busy | bus.wr_en;
  assign w_waddr     = w_busy ? r_cnt : bus.wr_addr;
  assign w_wdata     = w_busy ? INIT_VAL : bus.wr_data;
  assign w_re        = bus.rd_en & ~w_busy;
  assign bus.busy    = w_busy;
  assign bus.wr_drop = r_wr_drop;
  // next state: CLEAR ends on the edge writing the last address, RUN re-enters CLEAR on clr
  always_comb begin
    w_state_nxt = w_busy ? (w_last ? ST_RUN : ST_CLEAR) : (bus.clr ? ST_CLEAR : ST_RUN);
  end
  // state register; reset always restarts the clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_CLEAR;
    else r_state <= w_state_nxt;
  // clear address counter, parked at zero in RUN so a new clear starts from address 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
  // flag user writes rejected while the clear engine owns the write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wr_drop <= 1'b0;
    else r_wr_drop <= bus.wr_en & w_busy;
  // first valid stage tracks reads captured by the RAM read register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vld1 <= 1'b0;
    else r_vld1 <= w_re;
  sdp_mem_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_core_rd)
  );
  if (LAT2) begin : g_lat2
    logic              r_vld2;
    logic [DATA_W-1:0] r_dout;
    // output stage loads only when the first stage holds fresh data, otherwise holds
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_vld2 <= 1'b0;
        r_dout <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_dout <= w_core_rd;
      end
    assign bus.rd_valid = r_vld2;
    assign bus.rd_data  = r_dout;
  end else begin : g_lat1
    assign bus.rd_valid = r_vld1;
    assign bus.rd_data  = w_core_rd;
  end
endmodule

// File: tb/tb_dpram_sdp_clr.sv
// tb_dpram_sdp_clr: two builds (8x256 lat1 bypass, 16x16 lat2 no-bypass) checked against a memory model
module tb_dpram_sdp_clr;
  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b11;
  int total = 0, bad = 0, ecnt = 0;
  int vcnt [2] = '{0, 0};
  always #5 clk = ~clk;

  dpram_sdp_clr_if #(.DATA_W(8), .ADDR_W(8)) if_a ();
  dpram_sdp_clr_if #(.DATA_W(16), .ADDR_W(4)) if_b ();

  dpram_sdp_clr #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .BYPASS(1), .INIT_VAL(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .bus(if_a.slave));
  dpram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .BYPASS(0), .INIT_VAL(16'h005A)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .bus(if_b.slave));

  function automatic int dep(input int k); return k != 0 ? 16 : 256; endfunction
  function automatic int lat(input int k); return k != 0 ? 2 : 1; endfunction
  function automatic logic byp(input int k); return k == 0; endfunction
  function automatic logic [15:0] initv(input int k); return k != 0 ? 16'h005A : 16'h0000; endfunction
  function automatic logic busyk(input int k); return k != 0 ? if_b.busy : if_a.busy; endfunction
  function automatic logic [15:0] rdd(input int k); return k != 0 ? if_b.rd_data : {8'h00, if_a.rd_data}; endfunction
  function automatic logic rdv(input int k); return k != 0 ? if_b.rd_valid : if_a.rd_valid; endfunction

  // behavioural model: contents, remaining clear cycles, and reads in flight with their due edge
  typedef struct {int k; int due; logic [15:0] d;} rd_t;
  rd_t         q [$];
  logic [15:0] mm [2][256];
  int          left [2] = '{256, 16};
  logic        ev [2] = '{1'b0, 1'b0};
  logic        edrop [2] = '{1'b0, 1'b0};
  logic [15:0] ed [2] = '{16'h0, 16'h0};

  task automatic step(input int k, input logic r, input logic c, input logic we, input logic [7:0] wa,
                      input logic [15:0] wd, input logic re, input logic [7:0] ra);
    logic b;
    if (!r) begin
      left[k] = dep(k); ev[k] = 1'b0; ed[k] = '0; edrop[k] = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
      for (int i = 0; i < dep(k); i++) mm[k][i] = initv(k);
      return;
    end
    b = left[k] > 0;
    edrop[k] = we && b;
    if (re && !b) q.push_back('{k, ecnt + lat(k) - 1, (we && wa == ra && byp(k)) ? wd : mm[k][ra]});
    if (we && !b) mm[k][wa] = wd;
    if (b) left[k]--;
    else if (c) begin
      left[k] = dep(k);
      for (int i = 0; i < dep(k); i++) mm[k][i] = initv(k);
    end
    ev[k] = 1'b0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].k == k) begin
        if (q[i].due == ecnt) begin ev[k] = 1'b1; ed[k] = q[i].d; q.delete(i); end
        break;
      end
  endtask

  always @(posedge clk) begin
    ecnt++;
    step(0, rst_n[0], if_a.clr, if_a.wr_en, if_a.wr_addr, {8'h00, if_a.wr_data}, if_a.rd_en, if_a.rd_addr);
    step(1, rst_n[1], if_b.clr, if_b.wr_en, {4'h0, if_b.wr_addr}, if_b.wr_data, if_b.rd_en, {4'h0, if_b.rd_addr});
  end

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cmp(input int k, input logic r, input logic bz, input logic dr, input logic v, input logic [15:0] d);
    chk($sformatf("busy%0d", k), {15'h0, bz}, r ? {15'h0, left[k] > 0} : 16'h1);
    chk($sformatf("wr_drop%0d", k), {15'h0, dr}, r ? {15'h0, edrop[k]} : 16'h0);
    chk($sformatf("rd_valid%0d", k), {15'h0, v}, r ? {15'h0, ev[k]} : 16'h0);
    chk($sformatf("rd_data%0d", k), d, r ? ed[k] : 16'h0);
  endtask

  always @(negedge clk) if ($time > 2) begin
    cmp(0, rst_n[0], if_a.busy, if_a.wr_drop, if_a.rd_valid, {8'h00, if_a.rd_data});
    cmp(1, rst_n[1], if_b.busy, if_b.wr_drop, if_b.rd_valid, if_b.rd_data);
    if (if_a.rd_valid) vcnt[0]++;
    if (if_b.rd_valid) vcnt[1]++;
  end

  task automatic drv(input int k, input logic c, input logic we, input logic [7:0] wa, input logic [15:0] wd,
                     input logic re, input logic [7:0] ra);
    if (k == 0) begin
      if_a.clr = c; if_a.wr_en = we; if_a.wr_addr = wa; if_a.wr_data = wd[7:0]; if_a.rd_en = re; if_a.rd_addr = ra;
    end else begin
      if_b.clr = c; if_b.wr_en = we; if_b.wr_addr = wa[3:0]; if_b.wr_data = wd; if_b.rd_en = re; if_b.rd_addr = ra[3:0];
    end
  endtask

  task automatic cyc(input int k, input logic c, input logic we, input logic [7:0] wa, input logic [15:0] wd,
                     input logic re, input logic [7:0] ra);
    @(posedge clk); #1;
    drv(k, c, we, wa, wd, re, ra);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) cyc(k, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic rd_wait(input int k, input logic [15:0] e, input string n);
    idle(k, 1);
    repeat (lat(k) - 1) begin @(posedge clk); #1; end
    chk({n, "_vld"}, {15'h0, rdv(k)}, 16'h1);
    chk({n, "_dat"}, rdd(k), e);
  endtask

  task automatic rd_chk(input int k, input logic [7:0] a, input logic [15:0] e, input string n);
    cyc(k, 1'b0, 1'b0, 8'h0, 16'h0, 1'b1, a);
    rd_wait(k, e, n);
  endtask

  task automatic busy_len(output int na, output int nb);
    na = 0; nb = 0;
    for (int i = 0; i < 2000 && (busyk(0) || busyk(1)); i++) begin
      @(negedge clk);
      if (if_a.busy) na++;
      if (if_b.busy) nb++;
    end
  endtask

  initial begin
    int na, nb, n;
    drv(0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 8'h0);
    drv(1, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 8'h0);
    #1 rst_n = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 2'b11;
    busy_len(na, nb);
    chk("busy_len_a", 16'(na), 16'd256);
    chk("busy_len_b", 16'(nb), 16'd16);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) cyc(k, 1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 8'(i));
      idle(k, 3);
      rd_chk(k, 8'd2, k != 0 ? 16'h005A : 16'h0000, "init_rd");
      for (int i = 0; i < 16; i++) cyc(k, 1'b0, 1'b1, 8'(i), 16'(255 - i), 1'b0, 8'h0);
      idle(k, 20);
      vcnt[k] = 0;
      for (int i = 0; i < 16; i++) cyc(k, 1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 8'(i));
      idle(k, 4);
      chk("b2b_valid_cnt", 16'(vcnt[k]), 16'd16);
      rd_chk(k, 8'd5, 16'd250, "wr_rd5");
      cyc(k, 1'b0, 1'b1, 8'd7, 16'h003C, 1'b0, 8'h0);
      cyc(k, 1'b0, 1'b1, 8'd7, 16'h00A5, 1'b1, 8'd7);
      rd_wait(k, k != 0 ? 16'h003C : 16'h00A5, "collide");
      rd_chk(k, 8'd7, 16'h00A5, "after_collide");
      cyc(k, 1'b1, 1'b1, 8'd9, 16'h0011, 1'b1, 8'd4);
      cyc(k, 1'b0, 1'b1, 8'd3, 16'h0077, 1'b1, 8'd3);
      idle(k, 1);
      chk("clr_drop", {15'h0, k != 0 ? if_b.wr_drop : if_a.wr_drop}, 16'h1);
      chk("clr_busy", {15'h0, busyk(k)}, 16'h1);
      chk("clr_rd_done", rdd(k), 16'd251);
      idle(k, 1);
      vcnt[k] = 0;
      n = 0;
      while (busyk(k) && n < 2000) begin
        drv(k, 1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 8'd3);
        @(posedge clk); #1;
        n++;
      end
      drv(k, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 8'h0);
      chk("clr_timeout", {15'h0, busyk(k)}, 16'h0);
      chk("busy_rd_ignored", 16'(vcnt[k]), 16'd0);
      rd_chk(k, 8'd3, k != 0 ? 16'h005A : 16'h0000, "clr_rd3");
      rd_chk(k, 8'd9, k != 0 ? 16'h005A : 16'h0000, "clr_rd9");
    end
    cyc(0, 1'b1, 1'b0, 8'h0, 16'h0, 1'b0, 8'h0);
    idle(0, 100);
    rst_n[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n[0] = 1'b1;
    busy_len(na, nb);
    chk("rst_mid_clear_len", 16'(na), 16'd256);
    rd_chk(0, 8'd7, 16'h0000, "rst_rd7");
    cyc(1, 1'b0, 1'b1, 8'd15, 16'hFFFF, 1'b0, 8'h0);
    cyc(1, 1'b0, 1'b1, 8'd0, 16'h1234, 1'b0, 8'h0);
    idle(1, 1);
    rd_chk(1, 8'd15, 16'hFFFF, "b_rd15");
    rd_chk(1, 8'd0, 16'h1234, "b_rd0");
    rd_chk(1, 8'd1, 16'h005A, "b_nospill");
    idle(1, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
